gpr_wr_decoder: RTL

- Parametrised, multi-port successor to the 4-to-16 GPR write decoder.
- Decodes up to NPORTS write-back addresses into registered one-hot write strobes for the register array, with per-register port select.
- Resolves same-register write conflicts and keeps a pending-write scoreboard that raises read-after-write hazard flags for the two operand read ports.
- Sits between the write-back stage and the GPR array; hazard outputs feed issue stall logic.

---
 rtl/gpr_pkg.sv | 25 ++
 rtl/reg_decoder_p.sv | 15 +
 rtl/gpr_wr_decoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/gpr_pkg.sv
// Shared sizing helpers and constants for the GPR write-back decoder slice.
package gpr_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned REG_ZERO   = 0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned nregs_f(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Port-select fields are at least one bit wide, even with a single port.
  function automatic int unsigned psel_w_f(input int unsigned nports);
    return (clog2(nports) > 1) ? clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/reg_decoder_p.sv
// Enabled ADDR_W-to-2**ADDR_W one-hot decoder, one instance per write port.
module reg_decoder_p #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) onehot_c[addr] = 1'b1;
  end

endmodule

// File: rtl/gpr_wr_decoder.sv
// Multi-port GPR write decoder: conflict resolution, registered strobes,
// pending-write scoreboard and RAW hazard flags for two read ports.
module gpr_wr_decoder
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned R0_ZERO = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NPORTS-1:0]                            we,
  input  logic [NPORTS*ADDR_W-1:0]                     waddr,
  input  logic                                         issue_vld,
  input  logic [ADDR_W-1:0]                            issue_addr,
  input  logic                                         flush,
  input  logic [ADDR_W-1:0]                            raddr_a,
  input  logic [ADDR_W-1:0]                            raddr_b,
  output logic [nregs_f(ADDR_W)-1:0]                   out_d,
  output logic [nregs_f(ADDR_W)*psel_w_f(NPORTS)-1:0]  out_sel,
  output logic                                         conflict,
  output logic [nregs_f(ADDR_W)-1:0]                   busy,
  output logic                                         haz_a,
  output logic                                         haz_b
);

  localparam int unsigned NREGS  = nregs_f(ADDR_W);
  localparam int unsigned PSEL_W = psel_w_f(NPORTS);
  localparam bit          R0     = (R0_ZERO != 0);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [ADDR_W-1:0]       pa [NPORTS];
  logic [NPORTS-1:0]       acc_c;
  logic [NREGS-1:0]        onehot_c [NPORTS];
  logic [NREGS-1:0]        wr_mask_c;
  logic [NREGS-1:0]        issue_mask_c;
  logic                    conflict_c;
  logic [NREGS-1:0]        out_d_nxt;
  logic [NREGS*PSEL_W-1:0] out_sel_nxt;
  logic                    conflict_nxt;
  logic [NREGS-1:0]        busy_nxt;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign pa[g] = waddr[g*ADDR_W +: ADDR_W];

    reg_decoder_p #(.ADDR_W(ADDR_W)) u_dec (
      .en       (acc_c[g]),
      .addr     (pa[g]),
      .onehot_c (onehot_c[g])
    );
  end

  // Lowest enabled port wins a shared target; r0 writes vanish when hard-wired.
  always_comb begin
    acc_c      = '0;
    conflict_c = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      acc_c[p] = we[p] && !(R0 && (pa[p] == ZERO_ADDR));
      for (int q = 0; q < p; q++) begin
        if (we[q] && (pa[q] == pa[p])) begin
          acc_c[p] = 1'b0;
          if (we[p] && !(R0 && (pa[p] == ZERO_ADDR))) conflict_c = 1'b1;
        end
      end
    end
  end

  // Next-state for strobes, port selects and the scoreboard.
  always_comb begin
    wr_mask_c    = '0;
    out_sel_nxt  = '0;
    issue_mask_c = '0;
    for (int p = 0; p < NPORTS; p++) begin
      wr_mask_c = wr_mask_c | onehot_c[p];
      for (int r = 0; r < NREGS; r++) begin
        if (onehot_c[p][r]) out_sel_nxt[r*PSEL_W +: PSEL_W] = PSEL_W'(p);
      end
    end
    if (issue_vld && !(R0 && (issue_addr == ZERO_ADDR))) issue_mask_c[issue_addr] = 1'b1;

    out_d_nxt    = wr_mask_c;
    conflict_nxt = conflict_c;
    // A new producer outranks a same-cycle write-back to the same register.
    busy_nxt     = (busy & ~wr_mask_c) | issue_mask_c;
    if (flush) begin
      out_d_nxt    = '0;
      out_sel_nxt  = '0;
      conflict_nxt = 1'b0;
      busy_nxt     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_d    <= '0;
      out_sel  <= '0;
      conflict <= 1'b0;
      busy     <= '0;
    end else begin
      out_d    <= out_d_nxt;
      out_sel  <= out_sel_nxt;
      conflict <= conflict_nxt;
      busy     <= busy_nxt;
    end
  end

  // A write-back landing this cycle bypasses the pending hazard.
  assign haz_a = busy[raddr_a] && !wr_mask_c[raddr_a] && !(R0 && (raddr_a == ZERO_ADDR));
  assign haz_b = busy[raddr_b] && !wr_mask_c[raddr_b] && !(R0 && (raddr_b == ZERO_ADDR));

endmodule
